// File: rtl/piano_mode_sequencer.sv
// Generic N-mode sequencer for the digital piano: menu, song select, run, key-remap
// calibration, plus a free-running tick/time base. All outputs are registered.
module piano_mode_sequencer #(
  parameter int unsigned NKEYS     = 7,
  parameter int unsigned NMODES    = 5,
  parameter logic [NMODES-1:0] SONG_MASK = 5'b01110,
  parameter int unsigned NSONGS    = 3,
  parameter int unsigned DIFF_MAX  = 6,
  parameter int unsigned DIFF_INIT = 4,
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned TIME_W    = 16,
  localparam int unsigned MW = (NMODES > 1) ? $clog2(NMODES) : 1,
  localparam int unsigned SW = $clog2(NSONGS + 1),
  localparam int unsigned DW = $clog2(DIFF_MAX + 1),
  localparam int unsigned CW = $clog2(NKEYS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              submit_p,
  input  logic              cancel_p,
  input  logic              up_p,
  input  logic              down_p,
  input  logic [NKEYS-1:0]  note_key,
  output logic [NMODES-1:0] mode_en,
  output logic [MW-1:0]     active_mode,
  output logic [1:0]        state,
  output logic [SW-1:0]     song,
  output logic [SW-1:0]     preview_song,
  output logic [DW-1:0]     difficulty,
  output logic              map_we,
  output logic [NKEYS-1:0]  map_addr,
  output logic [NKEYS-1:0]  map_data,
  output logic              map_clr,
  output logic [CW-1:0]     cal_idx,
  output logic              cal_err,
  output logic              cal_done,
  output logic              tick,
  output logic [TIME_W-1:0] sys_time
);

  localparam logic [1:0] MENU   = 2'd0;
  localparam logic [1:0] SELECT = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] CAL    = 2'd3;

  localparam int unsigned KW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int unsigned VW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [1:0]        state_q, state_d;
  logic [NMODES-1:0] mode_en_q, mode_en_d;
  logic [MW-1:0]     active_mode_q, active_mode_d;
  logic [SW-1:0]     song_q, song_d;
  logic [SW-1:0]     preview_song_q, preview_song_d;
  logic [DW-1:0]     difficulty_q, difficulty_d;
  logic              map_we_q, map_we_d;
  logic [NKEYS-1:0]  map_addr_q, map_addr_d;
  logic [NKEYS-1:0]  map_data_q, map_data_d;
  logic              map_clr_q, map_clr_d;
  logic [CW-1:0]     cal_idx_q, cal_idx_d;
  logic              cal_err_q, cal_err_d;
  logic              cal_done_q, cal_done_d;
  logic [NKEYS-1:0]  used_q, used_d;
  logic [VW-1:0]     div_q, div_d;
  logic              tick_q, tick_d;
  logic [TIME_W-1:0] sys_time_q, sys_time_d;

  logic              key_valid;
  logic [KW-1:0]     key_idx;

  always_comb begin
    key_valid = (note_key != '0) && ((note_key & (note_key - NKEYS'(1))) == '0);
    key_idx   = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (note_key[i]) key_idx = KW'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    active_mode_d = active_mode_q;
    song_d        = song_q;
    difficulty_d  = difficulty_q;
    cal_idx_d     = cal_idx_q;
    used_d        = used_q;
    map_we_d      = 1'b0;
    map_addr_d    = '0;
    map_data_d    = '0;
    map_clr_d     = 1'b0;
    cal_err_d     = 1'b0;
    cal_done_d    = 1'b0;

    case (state_q)
      MENU: begin
        if (submit_p && key_valid && 32'(key_idx) < NMODES) begin
          active_mode_d = MW'(key_idx);
          if (32'(key_idx) == NMODES - 1) begin
            state_d   = CAL;
            cal_idx_d = '0;
            used_d    = '0;
          end else if (SONG_MASK[MW'(key_idx)]) begin
            state_d = SELECT;
          end else begin
            state_d = RUN;
          end
        end
      end
      SELECT: begin
        if (up_p && !down_p && 32'(difficulty_q) < DIFF_MAX)
          difficulty_d = difficulty_q + DW'(1);
        else if (down_p && !up_p && difficulty_q != '0)
          difficulty_d = difficulty_q - DW'(1);
        if (cancel_p) begin
          state_d = MENU;
          song_d  = '0;
        end else if (submit_p && key_valid && 32'(key_idx) < NSONGS) begin
          song_d  = SW'(32'(key_idx) + 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (cancel_p) begin
          state_d = MENU;
          song_d  = '0;
        end
      end
      default: begin
        if (cancel_p) begin
          state_d   = MENU;
          song_d    = '0;
          cal_idx_d = '0;
          map_clr_d = 1'b1;
        end else if (submit_p && key_valid) begin
          if (!used_q[key_idx]) begin
            map_we_d        = 1'b1;
            map_addr_d      = note_key;
            map_data_d      = NKEYS'(1) << cal_idx_q;
            used_d[key_idx] = 1'b1;
            cal_idx_d       = cal_idx_q + CW'(1);
            // The last write exits straight to MENU alongside the done pulse
            if (32'(cal_idx_q) + 1 == NKEYS) begin
              cal_done_d = 1'b1;
              state_d    = MENU;
              cal_idx_d  = '0;
            end
          end else begin
            cal_err_d = 1'b1;
          end
        end
      end
    endcase

    mode_en_d      = (state_d == RUN) ? (NMODES'(1) << active_mode_d) : '0;
    preview_song_d = '0;
    if (state_d == SELECT && key_valid && 32'(key_idx) < NSONGS)
      preview_song_d = SW'(32'(key_idx) + 1);
  end

  always_comb begin
    div_d      = div_q + VW'(1);
    tick_d     = 1'b0;
    sys_time_d = sys_time_q;
    if (32'(div_q) == TICK_DIV - 1) begin
      div_d      = '0;
      tick_d     = 1'b1;
      sys_time_d = sys_time_q + TIME_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= MENU;
      mode_en_q      <= '0;
      active_mode_q  <= '0;
      song_q         <= '0;
      preview_song_q <= '0;
      difficulty_q   <= DW'(DIFF_INIT);
      map_we_q       <= 1'b0;
      map_addr_q     <= '0;
      map_data_q     <= '0;
      map_clr_q      <= 1'b0;
      cal_idx_q      <= '0;
      cal_err_q      <= 1'b0;
      cal_done_q     <= 1'b0;
      used_q         <= '0;
      div_q          <= '0;
      tick_q         <= 1'b0;
      sys_time_q     <= '0;
    end else begin
      state_q        <= state_d;
      mode_en_q      <= mode_en_d;
      active_mode_q  <= active_mode_d;
      song_q         <= song_d;
      preview_song_q <= preview_song_d;
      difficulty_q   <= difficulty_d;
      map_we_q       <= map_we_d;
      map_addr_q     <= map_addr_d;
      map_data_q     <= map_data_d;
      map_clr_q      <= map_clr_d;
      cal_idx_q      <= cal_idx_d;
      cal_err_q      <= cal_err_d;
      cal_done_q     <= cal_done_d;
      used_q         <= used_d;
      div_q          <= div_d;
      tick_q         <= tick_d;
      sys_time_q     <= sys_time_d;
    end
  end

  assign state        = state_q;
  assign mode_en      = mode_en_q;
  assign active_mode  = active_mode_q;
  assign song         = song_q;
  assign preview_song = preview_song_q;
  assign difficulty   = difficulty_q;
  assign map_we       = map_we_q;
  assign map_addr     = map_addr_q;
  assign map_data     = map_data_q;
  assign map_clr      = map_clr_q;
  assign cal_idx      = cal_idx_q;
  assign cal_err      = cal_err_q;
  assign cal_done     = cal_done_q;
  assign tick         = tick_q;
  assign sys_time     = sys_time_q;

endmodule

// File: doc/piano_mode_sequencer.md
# piano_mode_sequencer

Parametrised top-level mode sequencer for the digital piano. It replaces the fixed five-mode controller FSM with a generic one:
- N one-hot-selected modes, each enabled through its own `mode_en` bit.
- Per-mode song-selection sub-phase and saturating difficulty selection.
- Duplicate-checked key-remap calibration that drives the key-map RAM write port.
- Free-running system tick and time base.

It sits between the debounced button pulses and the mode engines and output muxes.

## Interface
- NKEYS, 7, note keys and key-map RAM depth
- NMODES, 5, selectable modes (2..NKEYS); mode NMODES-1 is calibration
- SONG_MASK, 5'b01110, bit k set: mode k requires song selection
- NSONGS, 3, selectable songs (1..NKEYS)
- DIFF_MAX, 6, max difficulty
- DIFF_INIT, 4, difficulty after reset (≤DIFF_MAX)
- TICK_DIV, 100000, clk cycles per tick (≥2)
- TIME_W, 16, sys_time width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- submit_p, cancel_p, up_p, down_p  in  1 each  single-cycle debounced pulses
- note_key  in  NKEYS  raw key levels
- mode_en  out  NMODES  one-hot run enable, or all zero
- active_mode  out  clog2(NMODES)  selected mode index
- state  out  2  MENU=0, SELECT=1, RUN=2, CAL=3
- song  out  clog2(NSONGS+1)  latched song, 0 = none
- preview_song  out  clog2(NSONGS+1)  song under the key, SELECT only
- difficulty  out  clog2(DIFF_MAX+1)  current difficulty
- map_we  out  1  RAM write strobe
- map_addr  out  NKEYS  written key (one-hot)
- map_data  out  NKEYS  mapped note (one-hot)
- map_clr  out  1  pulse: RAM returns to identity map
- cal_idx  out  clog2(NKEYS+1)  next note index to calibrate
- cal_err, cal_done  out  1 each  single-cycle pulses
- tick  out  1  one-cycle pulse every TICK_DIV clks
- sys_time  out  TIME_W  tick count; wraps

## Operation
- **Valid key:** note_key is exactly one-hot. "k" denotes its bit index.
- **Output style:** all outputs are registered; pulses are high for exactly one cycle.
- **Cancel:** in SELECT, RUN or CAL, cancel_p → MENU.
  - Clears mode_en, song, preview_song and cal_idx.
  - In CAL it also pulses map_clr.
  - Cancel beats submit in the same cycle; cancel in MENU is ignored.
- **MENU:** submit_p with valid k<NMODES sets active_mode=k, then:
  - k=NMODES-1 → CAL, cal_idx=0, used-mask cleared.
  - else SONG_MASK[k] → SELECT.
  - else → RUN.
  - Invalid key or k≥NMODES → stay in MENU.
- **SELECT:**
  - preview_song = k+1 if valid and k<NSONGS, else 0; updated every cycle.
  - up_p increments difficulty and down_p decrements it, both saturating at DIFF_MAX/0.
  - up_p and down_p together → no change.
  - up_p/down_p are ignored outside SELECT.
  - submit_p with preview-valid key → song=k+1, RUN. Otherwise stay in SELECT.
- **RUN:** mode_en = 1<<active_mode while in RUN. submit/up/down are ignored here; the mode engine consumes them.
- **CAL:** submit_p with valid key:
  - If the key's used-mask bit is clear:
    - map_we=1, map_addr=note_key, map_data=1<<cal_idx.
    - Set the used-mask bit; cal_idx++.
  - If the key is already used → cal_err, no write.
  - Invalid key → ignored.
  - When cal_idx reaches NKEYS → cal_done pulse, MENU, cal_idx=0.
- **Tick:**
  - Divider counts 0..TICK_DIV-1 in every state.
  - tick is asserted in the cycle the divider wraps; sys_time increments in that same cycle.
- **Reset values:**
  - state=MENU; mode_en, active_mode, song, preview_song = 0.
  - difficulty=DIFF_INIT.
  - map_* and cal_* = 0.
  - Divider, tick and sys_time = 0.
  - Reset does not pulse map_clr.
  - Asynchronous reset mid-operation returns all registers to these values immediately.

## Timing
- **Submit:** pulse sampled at edge n → state/song/active_mode change at n+1. mode_en is high from n+1 for a direct-RUN mode.
- **Difficulty:** up_p/down_p at edge n → new difficulty visible at n+1.
- **preview_song:** lags note_key by 1 cycle.
- **CAL write:**
  - map_we/addr/data valid exactly one cycle, at n+1.
  - cal_idx updates at n+1.
  - The final write and cal_done are asserted in the same cycle; state=MENU in that cycle.
- **Cancel:** cancel_p at n → state=MENU, mode_en=0 and map_clr at n+1.
- **Back-to-back submits:** in consecutive cycles each is processed against the state current at that edge.
- **Tick:** period exactly TICK_DIV cycles; first tick at cycle TICK_DIV after reset release. sys_time wraps from 2^TIME_W-1 to 0.

## Test plan
- **Direct mode:** reset, submit with note_key=7'b0000001 → state=RUN, mode_en=5'b00001 one cycle later; cancel → MENU, mode_en=0.
- **Song mode and difficulty:** key 7'b0000010 → SELECT. Then:
  - up_p ×3 → difficulty=6 (saturates).
  - down_p+up_p together → stays 6.
  - key 7'b0000100 shows preview_song=3; submit → song=3, mode_en=5'b00010.
- **Invalid selection:** in MENU submit with 7'b0000011, then with 7'b0100000 → state stays MENU. In SELECT submit with 7'b1000000 → stays SELECT, song=0.
- **Calibration:** enter CAL, submit keys 64,32,16,8,4,2,1. Expect:
  - Seven map_we pulses with map_data=1,2,4,…,64.
  - cal_done on the 7th write, then MENU.
  - Repeating key 64 as the 2nd submit → cal_err, no map_we, cal_idx stays 1.
- **Cancel and reset mid-calibration:**
  - cancel_p together with submit_p at cal_idx=3 → map_clr pulse, no map_we, MENU.
  - Async rst_n low mid-CAL → all outputs at reset values before the next clk edge.
- **Tick (TICK_DIV=4, TIME_W=2):** tick high at cycles 4,8,12,16. sys_time reads 1,2,3,0 after those ticks.
